// File: rtl/risc_v_mike_fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode stage.
// Purely wires: no state, no added latency.
// Request and decode sides are valid/ready; the memory response side is never back-pressured.
interface risc_v_mike_fetch_unit_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [PC_W-1:0]    dec_pc;
    logic [31:0]        perf_stall_cnt;
    logic [31:0]        perf_flush_cnt;

    // fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output dec_valid, dec_instr, dec_pc,
        input  dec_ready,
        output perf_stall_cnt, perf_flush_cnt
    );

    // memory / decode / branch-unit side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  dec_valid, dec_instr, dec_pc,
        output dec_ready,
        input  perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/risc_v_mike_fetch_unit.sv
// Instruction fetch front end: PC generation, in-order prefetch buffer, redirect flush.
// Latency: response accepted in cycle N is offered to decode in N+1 (memory latency + 1 overall).
// Backpressure: requests stop when buffer slots plus pending discards reach FIFO_DEPTH; decode stalls hold entries.
// Optional perf counters are built when RISC_V_MIKE_FETCH_PERF_EN is defined; otherwise they read 0.
module risc_v_mike_fetch_unit #(
    parameter int              PC_W         = 32,
    parameter int              INSTR_W      = 32,
    parameter int              FIFO_DEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    risc_v_mike_fetch_unit_if.master bus
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    ent_pc    [FIFO_DEPTH];
    logic [INSTR_W-1:0] ent_instr [FIFO_DEPTH];

    // alloc: next slot to request, fill: next slot awaiting data, rd: next slot for decode
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] rd_ptr;
    // responses still owed for requests orphaned by a redirect
    logic [PTR_W-1:0] drop_cnt;

    logic [PTR_W-1:0] occ;
    logic [PTR_W-1:0] outstanding;
    logic [CNT_W-1:0] credit_used;
    logic             req_valid;
    logic             dec_valid;
    logic             req_fire;
    logic             rsp_ok;
    logic             dec_fire;
    logic [1:0]       unused_redirect_lsb;

    assign occ         = alloc_ptr - rd_ptr;
    assign outstanding = (alloc_ptr - fill_ptr) + drop_cnt;
    assign credit_used = {1'b0, occ} + {1'b0, drop_cnt};

    // Discarded responses still hold a credit so the memory never has more in flight than we can absorb.
    assign req_valid = !rst && (credit_used < DEPTH_CNT);
    assign dec_valid = (fill_ptr != rd_ptr);

    assign req_fire = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign rsp_ok   = bus.imem_rsp_valid && (outstanding != '0);
    assign dec_fire = dec_valid && bus.dec_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.dec_valid      = dec_valid;
    assign bus.dec_instr      = ent_instr[rd_ptr[IDX_W-1:0]];
    assign bus.dec_pc         = ent_pc[rd_ptr[IDX_W-1:0]];

    assign unused_redirect_lsb = bus.redirect_pc[1:0];

    // PC, buffer pointers and entries; redirect wins over every other update
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_VECTOR;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_pc[i]    <= '0;
                ent_instr[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            fetch_pc  <= {bus.redirect_pc[PC_W-1:2], 2'b00};
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            // everything in flight, plus a request issued now, minus a response consumed now
            drop_cnt  <= outstanding + PTR_W'(req_fire) - PTR_W'(rsp_ok);
        end else begin
            if (req_fire) begin
                ent_pc[alloc_ptr[IDX_W-1:0]] <= fetch_pc;
                alloc_ptr                    <= alloc_ptr + PTR_ONE;
                fetch_pc                     <= fetch_pc + PC_W'(4);
            end
            if (rsp_ok) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - PTR_ONE;
                end else if (fill_ptr != alloc_ptr) begin
                    ent_instr[fill_ptr[IDX_W-1:0]] <= bus.imem_rsp_data;
                    fill_ptr                       <= fill_ptr + PTR_ONE;
                end
            end
            if (dec_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

`ifdef RISC_V_MIKE_FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // saturating counts of decode-starved cycles and thrown-away responses
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!dec_valid && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (rsp_ok && (bus.redirect_valid || (drop_cnt != '0)) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_flush_cnt = flush_cnt;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
`endif
endmodule
